// File: rtl/matrix_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_alu_pkg
//  Description : Shared definitions for the sequential matrix ALU: opcode
//                constants, controller state encoding and small helpers for
//                locating packed elements and detecting saturation.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_alu_pkg;

    localparam int unsigned c_OP_W = 3;

    localparam logic [c_OP_W-1:0] c_OP_ADD       = 3'd0;
    localparam logic [c_OP_W-1:0] c_OP_SUB       = 3'd1;
    localparam logic [c_OP_W-1:0] c_OP_TRANSPOSE = 3'd2;
    localparam logic [c_OP_W-1:0] c_OP_SCALE     = 3'd3;
    localparam logic [c_OP_W-1:0] c_OP_MUL       = 3'd4;
    localparam logic [c_OP_W-1:0] c_OP_LAST      = c_OP_MUL;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    // Wide enough for the largest accumulator (2*32 + clog2(8) = 67 bits).
    localparam int unsigned c_WIDE_W = 72;

    // LSB position of element (row, col) in a packed DIM x DIM matrix.
    function automatic int unsigned elem_lsb(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned dim,
                                             input int unsigned elem_w);
        return (row * dim + col) * elem_w;
    endfunction

    // True when a value does not fit in elem_w bits, i.e. saturating
    // truncation must clamp rather than keep the low bits.
    function automatic logic exceeds_width(input logic [c_WIDE_W-1:0] value,
                                           input int unsigned          elem_w);
        return (value >> elem_w) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_alu_seq_if
//  Description : Operand-load, control and result-output bundle between the
//                execution unit (master) and the matrix ALU (slave).
//  Ports       : in_valid/in_ready/in_sel/in_data - operand load handshake
//                start/op/saturate                - operation request
//                busy/err                         - status
//                out_valid/out_ready/out_data     - result handshake
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_alu_seq_if
    import matrix_alu_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int ELEM_W = 16
);
    localparam int c_MAT_W = DIM * DIM * ELEM_W;

    logic                in_valid;
    logic                in_ready;
    logic                in_sel;
    logic [c_MAT_W-1:0]  in_data;
    logic                start;
    logic [c_OP_W-1:0]   op;
    logic                saturate;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [c_MAT_W-1:0]  out_data;
    logic                err;

    modport master (
        output in_valid, in_sel, in_data, start, op, saturate, out_ready,
        input  in_ready, busy, out_valid, out_data, err
    );

    modport slave (
        input  in_valid, in_sel, in_data, start, op, saturate, out_ready,
        output in_ready, busy, out_valid, out_data, err
    );
endinterface
`default_nettype wire

// File: rtl/matrix_mac_elem.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_mac_elem
//  Description : Per-element arithmetic unit. Holds the multiply/accumulate
//                register and the saturate-or-wrap output stage. The output
//                is combinational from the value being written this cycle so
//                the controller can store it on the same edge.
//  Ports       : clk, nReset     - clock, async active-low reset
//                en, clear       - accumulate enable, start a fresh sum
//                op, sat         - operation, saturating mode
//                a, b            - element operands
//                res             - finished element
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_mac_elem
    import matrix_alu_pkg::*;
#(
    parameter int ELEM_W = 16,
    parameter int ACC_W  = 34
) (
    input  wire logic              clk,
    input  wire logic              nReset,
    input  wire logic              en,
    input  wire logic              clear,
    input  wire logic [c_OP_W-1:0] op,
    input  wire logic              sat,
    input  wire logic [ELEM_W-1:0] a,
    input  wire logic [ELEM_W-1:0] b,
    output logic      [ELEM_W-1:0] res
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_term;
    logic [ACC_W-1:0] w_acc_next;

    always_comb begin
        w_term = '0;
        if (op == c_OP_ADD) begin
            w_term = ACC_W'(a) + ACC_W'(b);
        end else begin
            // SCALE and MULTIPLY both form a product; SUB uses its own path.
            w_term = ACC_W'(a) * ACC_W'(b);
        end

        w_acc_next = (clear ? '0 : r_acc) + w_term;

        res = w_acc_next[ELEM_W-1:0];
        if (op == c_OP_SUB) begin
            res = (sat && (a < b)) ? '0 : (a - b);
        end else if (sat && exceeds_width({{(c_WIDE_W-ACC_W){1'b0}}, w_acc_next}, ELEM_W)) begin
            res = '1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_acc_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/matrix_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_alu_seq
//  Description : Sequential DIM x DIM matrix ALU (ADD, SUB, TRANSPOSE, SCALE,
//                MULTIPLY), one result element per cycle, wrap or saturate.
//                Operands A and B persist across operations.
//  Ports       : clk    - clock, rising edge
//                nReset - asynchronous active-low reset
//                bus    - matrix_alu_seq_if slave (load, control, result)
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_alu_seq
    import matrix_alu_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int ELEM_W = 16
) (
    input  wire logic          clk,
    input  wire logic          nReset,
    matrix_alu_seq_if.slave    bus
);
    localparam int MAT_W   = DIM * DIM * ELEM_W;
    localparam int c_ACC_W = 2 * ELEM_W + $clog2(DIM);
    localparam int c_CNT_W = $clog2(DIM);
    localparam int c_LSB_W = $clog2(MAT_W);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIM - 1);

    state_e              r_state, w_state_next;
    logic [MAT_W-1:0]    r_a, r_b, r_r, r_out_data;
    logic                r_out_valid, r_err, r_sat, r_drain;
    logic [c_OP_W-1:0]   r_op;
    logic [c_CNT_W-1:0]  r_row, r_col, r_k;

    logic                w_is_mul, w_k_last, w_last_elem, w_mac_en, w_mac_clear;
    logic [c_LSB_W-1:0]  w_lsb_a, w_lsb_b, w_lsb_dst, w_lsb_tr;
    logic [ELEM_W-1:0]   w_elem_a, w_elem_b, w_mac_res, w_elem;

    // ---------------- element addressing ----------------
    always_comb begin
        w_is_mul    = (r_op == c_OP_MUL);
        w_k_last    = !w_is_mul || (r_k == c_LAST);
        w_last_elem = (r_row == c_LAST) && (r_col == c_LAST) && w_k_last;

        w_lsb_dst = c_LSB_W'(elem_lsb(32'(r_row), 32'(r_col), DIM, ELEM_W));
        w_lsb_tr  = c_LSB_W'(elem_lsb(32'(r_col), 32'(r_row), DIM, ELEM_W));
        w_lsb_a   = w_lsb_dst;
        w_lsb_b   = w_lsb_dst;
        if (w_is_mul) begin
            w_lsb_a = c_LSB_W'(elem_lsb(32'(r_row), 32'(r_k), DIM, ELEM_W));
            w_lsb_b = c_LSB_W'(elem_lsb(32'(r_k), 32'(r_col), DIM, ELEM_W));
        end

        w_elem_a = r_a[w_lsb_a +: ELEM_W];
        w_elem_b = (r_op == c_OP_SCALE) ? r_b[ELEM_W-1:0] : r_b[w_lsb_b +: ELEM_W];
        w_elem   = (r_op == c_OP_TRANSPOSE) ? r_a[w_lsb_tr +: ELEM_W] : w_mac_res;

        w_mac_en    = (r_state == S_COMPUTE) && !r_drain && (r_op != c_OP_TRANSPOSE);
        w_mac_clear = !w_is_mul || (r_k == '0);
    end

    matrix_mac_elem #(
        .ELEM_W (ELEM_W),
        .ACC_W  (c_ACC_W)
    ) u_mac (
        .clk    (clk),
        .nReset (nReset),
        .en     (w_mac_en),
        .clear  (w_mac_clear),
        .op     (r_op),
        .sat    (r_sat),
        .a      (w_elem_a),
        .b      (w_elem_b),
        .res    (w_mac_res)
    );

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.busy     = (r_state != S_IDLE);
        // in_ready is forced low while reset is held.
        bus.in_ready = nReset && (r_state == S_IDLE) && !bus.start;
        case (r_state)
            S_IDLE: begin
                if (bus.start && (bus.op <= c_OP_LAST)) begin
                    w_state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // The drain cycle follows the last element write so that
                // out_data is copied from a fully updated R.
                if (r_drain) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_r         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_op        <= c_OP_ADD;
            r_sat       <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_drain     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_err   <= (bus.op > c_OP_LAST);
                        r_op    <= bus.op;
                        r_sat   <= bus.saturate;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_k     <= '0;
                        r_drain <= 1'b0;
                    end else if (bus.in_valid) begin
                        if (bus.in_sel) begin
                            r_b <= bus.in_data;
                        end else begin
                            r_a <= bus.in_data;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (r_drain) begin
                        r_out_data  <= r_r;
                        r_out_valid <= 1'b1;
                    end else begin
                        if (w_k_last) begin
                            r_r[w_lsb_dst +: ELEM_W] <= w_elem;
                        end
                        if (w_last_elem) begin
                            r_drain <= 1'b1;
                        end
                        if (!w_k_last) begin
                            r_k <= r_k + 1'b1;
                        end else begin
                            r_k <= '0;
                            if (r_col == c_LAST) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_matrix_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_alu_seq
//  Description : Directed self-checking bench for matrix_alu_seq (DIM=4,
//                ELEM_W=16). Expected results come from a behavioural model
//                and are queued at start, then popped at out_valid.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_alu_seq;
    localparam int D    = 4;
    localparam int W    = 16;
    localparam int MW   = D * D * W;
    localparam longint unsigned MAXV = (64'd1 << W) - 1;

    typedef logic [MW-1:0] mat_t;

    logic clk;
    logic nReset;

    matrix_alu_seq_if #(.DIM(D), .ELEM_W(W)) bus ();

    matrix_alu_seq #(.DIM(D), .ELEM_W(W)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_cnt;
    mat_t ma, mb;
    mat_t exp_q[$];

    task automatic check(input string tag, input mat_t obs, input mat_t exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic mat_t model(input logic [2:0] o, input bit sat,
                                   input mat_t a, input mat_t b);
        mat_t res = '0;
        longint unsigned v, ea, eb;
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                ea = a[(r*D+c)*W +: W];
                eb = b[(r*D+c)*W +: W];
                v  = 0;
                case (o)
                    3'd0: v = ea + eb;
                    3'd1: v = (ea >= eb) ? ea - eb : (sat ? 0 : ea + (MAXV + 1) - eb);
                    3'd2: v = a[(c*D+r)*W +: W];
                    3'd3: v = ea * b[W-1:0];
                    3'd4: for (int k = 0; k < D; k++)
                              v += a[(r*D+k)*W +: W] * b[(k*D+c)*W +: W];
                    default: v = 0;
                endcase
                if (v > MAXV) v = sat ? MAXV : (v & MAXV);
                res[(r*D+c)*W +: W] = v[W-1:0];
            end
        end
        return res;
    endfunction

    task automatic load(input bit sel, input mat_t data);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (sel) mb = data; else ma = data;
    endtask

    // Starts an op, waits for out_valid, checks latency/err/data.
    task automatic start_and_wait(input string tag, input logic [2:0] o,
                                  input bit sat, input int exp_lat);
        int   n;
        bit   err_seen;
        mat_t e;
        exp_q.push_back(model(o, sat, ma, mb));
        bus.op = o; bus.saturate = sat; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0; busy_cnt = 0; err_seen = 0;
        while (!bus.out_valid && n < 2000) begin
            if (bus.busy) busy_cnt++;
            if (bus.err)  err_seen = 1;
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, mat_t'(n), mat_t'(exp_lat));
        check({tag, " err"}, mat_t'(err_seen), '0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, " data"}, bus.out_data, e);
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid drop"}, mat_t'(bus.out_valid), '0);
        check({tag, " idle in_ready"}, mat_t'(bus.in_ready), mat_t'(1));
    endtask

    initial begin
        mat_t tmp, held;
        int   ok_valid, ok_stable, ok_ready;

        clk = 0; nReset = 0;
        bus.in_valid = 0; bus.in_sel = 0; bus.in_data = '0;
        bus.start = 0; bus.op = '0; bus.saturate = 0; bus.out_ready = 0;
        ma = '0; mb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready",  mat_t'(bus.in_ready),  '0);
        check("rst busy",      mat_t'(bus.busy),      '0);
        check("rst out_valid", mat_t'(bus.out_valid), '0);
        check("rst out_data",  bus.out_data,          '0);
        check("rst err",       mat_t'(bus.err),       '0);
        nReset = 1;
        #1;
        check("post-rst in_ready", mat_t'(bus.in_ready), mat_t'(1));

        // ADD: A(i)=i, B=1
        for (int i = 0; i < D*D; i++) tmp[i*W +: W] = W'(i);
        load(0, tmp);
        for (int i = 0; i < D*D; i++) tmp[i*W +: W] = W'(1);
        load(1, tmp);
        start_and_wait("add", 3'd0, 0, D*D + 1);
        release_out("add");

        // MULTIPLY: identity x B(i)=3i
        tmp = '0;
        for (int i = 0; i < D; i++) tmp[(i*D+i)*W +: W] = W'(1);
        load(0, tmp);
        for (int i = 0; i < D*D; i++) tmp[i*W +: W] = W'(3*i);
        load(1, tmp);
        start_and_wait("mul", 3'd4, 0, D*D*D + 1);
        check("mul busy cycles", mat_t'(busy_cnt), mat_t'(D*D*D + 1));
        check("mul equals B", bus.out_data, mb);
        release_out("mul");

        // SUB: 5 - 7
        for (int i = 0; i < D*D; i++) tmp[i*W +: W] = W'(5);
        load(0, tmp);
        for (int i = 0; i < D*D; i++) tmp[i*W +: W] = W'(7);
        load(1, tmp);
        start_and_wait("sub wrap", 3'd1, 0, D*D + 1);
        check("sub wrap elem0", mat_t'(bus.out_data[W-1:0]), mat_t'(16'hFFFE));
        release_out("sub wrap");
        start_and_wait("sub sat", 3'd1, 1, D*D + 1);
        release_out("sub sat");

        // SCALE: 0x4000 * 8
        for (int i = 0; i < D*D; i++) tmp[i*W +: W] = W'(16'h4000);
        load(0, tmp);
        tmp = '0; tmp[W-1:0] = W'(8);
        load(1, tmp);
        start_and_wait("scale sat", 3'd3, 1, D*D + 1);
        check("scale sat elem5", mat_t'(bus.out_data[5*W +: W]), mat_t'(16'hFFFF));
        release_out("scale sat");
        start_and_wait("scale wrap", 3'd3, 0, D*D + 1);
        release_out("scale wrap");

        // TRANSPOSE of A(i)=i
        for (int i = 0; i < D*D; i++) tmp[i*W +: W] = W'(i);
        load(0, tmp);
        start_and_wait("transpose", 3'd2, 0, D*D + 1);
        check("transpose (r1,c2)", mat_t'(bus.out_data[(1*D+2)*W +: W]), mat_t'(4*2+1));
        release_out("transpose");

        // DONE hold with operand reuse; start attempts must be ignored
        start_and_wait("hold", 3'd0, 0, D*D + 1);
        held = bus.out_data;
        ok_valid = 0; ok_stable = 0; ok_ready = 0;
        bus.start = 1; bus.op = 3'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) ok_valid++;
            if (bus.out_data === held)  ok_stable++;
            if (bus.in_ready === 1'b0)  ok_ready++;
        end
        bus.start = 0;
        check("hold out_valid", mat_t'(ok_valid),  mat_t'(10));
        check("hold stable",    mat_t'(ok_stable), mat_t'(10));
        check("hold in_ready",  mat_t'(ok_ready),  mat_t'(10));
        release_out("hold");
        check("hold busy after", mat_t'(bus.busy), '0);

        // Illegal op
        bus.op = 3'd6; bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        check("illegal err pulse", mat_t'(bus.err),  mat_t'(1));
        check("illegal busy",      mat_t'(bus.busy), '0);
        @(posedge clk); #1;
        check("illegal err clears", mat_t'(bus.err), '0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal no out_valid", mat_t'(bus.out_valid), '0);

        // Reset mid-MULTIPLY
        for (int i = 0; i < D*D; i++) tmp[i*W +: W] = W'(2);
        load(0, tmp);
        for (int i = 0; i < D*D; i++) tmp[i*W +: W] = W'(3);
        load(1, tmp);
        bus.op = 3'd4; bus.saturate = 0; bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (30) @(posedge clk);
        #1;
        check("pre-rst busy", mat_t'(bus.busy), mat_t'(1));
        nReset = 0;
        #1;
        check("mid-rst busy",      mat_t'(bus.busy),      '0);
        check("mid-rst out_valid", mat_t'(bus.out_valid), '0);
        check("mid-rst out_data",  bus.out_data,          '0);
        check("mid-rst in_ready",  mat_t'(bus.in_ready),  '0);
        @(posedge clk); #1;
        nReset = 1;
        ma = '0; mb = '0;
        #1;
        // A and B must now be zero: an ADD without reloading yields zero.
        start_and_wait("post-rst add", 3'd0, 0, D*D + 1);
        release_out("post-rst add");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/matrix_alu_seq.md
Name: matrix_alu_seq

Overview:
Parametrised successor to the fixed 4x4 matrix ALU. Performs ADD, SUBTRACT, TRANSPOSE, SCALE and MULTIPLY on DIM x DIM matrices of ELEM_W-bit unsigned elements.
- Adds a wrap or saturate arithmetic mode, valid/ready handshakes on operand load and result output, and an illegal-op error.
- Computes one result element at a time. Sits between the execution unit (operand source and result sink) and the shared matrix bus.

Parameters:
DIM, 4, matrix rows and columns (2..8)
ELEM_W, 16, element width in bits (4..32)
MAT_W, DIM*DIM*ELEM_W, packed matrix width (localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
nReset  input  1  asynchronous active-low reset
in_valid  input  1  operand word valid
in_ready  output  1  operand word accepted when high with in_valid
in_sel  input  1  0 = load A, 1 = load B/scalar
in_data  input  MAT_W  packed operand
start  input  1  begin operation, sampled only in IDLE
op  input  3  0 ADD, 1 SUBTRACT, 2 TRANSPOSE, 3 SCALE, 4 MULTIPLY
saturate  input  1  1 = saturating arithmetic, 0 = modulo 2^ELEM_W
busy  output  1  high whenever state != IDLE
out_valid  output  1  result valid
out_ready  input  1  result sink ready
out_data  output  MAT_W  packed result
err  output  1  one-cycle pulse on an illegal op

Behaviour:
- Clock is clk. Reset is nReset: asynchronous, active-low. The clock and reset polarity/synchronicity are fixed.
- Reset values: in_ready 0 during reset, busy 0, out_valid 0, out_data 0, err 0. Registers A, B and result R are all cleared to 0. State is IDLE. No Z values anywhere.
- Packing: element (r,c) occupies bits [(r*DIM+c)*ELEM_W +: ELEM_W]. Row 0, column 0 is in the LSBs.
- Scalar for SCALE: B[ELEM_W-1:0], i.e. element (0,0) of B.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready = !start.
  - An in_valid handshake writes in_data into A or B, selected by in_sel.
  - If start and in_valid are both high, start wins and no load occurs.
  - On start, op and saturate are latched.
  - If op > 4: err pulses high for one cycle, state stays IDLE, no out_valid.
  - Otherwise: clear element index idx and inner counter k, then go to COMPUTE.
- COMPUTE:
  - ADD, SUB, SCALE: R[idx] = f(A[idx], B[idx] or scalar). One element per cycle, DIM*DIM cycles total.
  - TRANSPOSE: R[r][c] = A[c][r]. One element per cycle, DIM*DIM cycles.
  - MULTIPLY: the accumulator is cleared at k=0, then accumulates A[r][k]*B[k][c] for k = 0..DIM-1. The saturated/truncated element is written on k = DIM-1. DIM^3 cycles total.
  - After the last element, go to DONE. out_data is loaded from R on the same edge.
- Latency: start sampled at edge t gives out_valid high after edge t+C+1, where C = DIM*DIM, or DIM^3 for MULTIPLY.
- DONE:
  - out_valid held high and out_data held stable until out_ready.
  - On the out_valid && out_ready edge, out_valid drops and the block returns to IDLE.
  - in_ready = 0 and start is ignored while busy.
- Arithmetic and widths:
  - Accumulator width is 2*ELEM_W + clog2(DIM).
  - saturate=0: results are truncated to ELEM_W bits.
  - saturate=1: ADD and SCALE clamp to 2^ELEM_W-1. SUB clamps to 0 on underflow. MULTIPLY clamps the final accumulator to 2^ELEM_W-1.
- A and B are retained after an operation, so consecutive ops may reuse operands without reloading.
- nReset asserted mid-operation immediately returns all state and outputs to reset values. The in-flight result is discarded.

Decomposition:
- Package matrix_alu_pkg holds:
  - op code constants (ADD..MULTIPLY)
  - the state enum
  - functions for packed-element index and saturating truncation.
- One natural sub-module: matrix_mac_elem. It holds the accumulator, the clear/accumulate/finalise controls, and the saturate-or-wrap output stage. It is shared by all ops; TRANSPOSE bypasses it.

Test Plan:
- DIM=4, ELEM_W=16. A element i = i, B all 1, ADD, saturate=0 -> out element i = i+1; out_valid exactly 17 cycles after start; err 0.
- A = identity, B element i = 3*i, MULTIPLY -> out_data == B; out_valid at start+65; busy high for 65 cycles.
- A all 5, B all 7, SUB: saturate=0 -> every element 0xFFFE; saturate=1 -> every element 0x0000.
- A all 0x4000, B low element 8, SCALE: saturate=1 -> all 0xFFFF; saturate=0 -> all 0x0000. TRANSPOSE of A element i = i -> out(r,c) = 4c+r.
- Hold out_ready low for 10 cycles in DONE -> out_valid stays 1, out_data stable, in_ready 0, start ignored. Raise out_ready -> IDLE next cycle, in_ready 1.
- op=6 with start -> err high exactly 1 cycle, busy 0, no out_valid. Assert nReset at cycle 30 of a MULTIPLY -> busy, out_valid and out_data go to 0 immediately, A/B read back 0.
